// File: rtl/ov5640_pkg.sv
// Shared constants and state encoding for the OV5640 power-up register sequencer.
package ov5640_pkg;

  localparam int unsigned CFG_WORD_W    = 24;
  localparam logic [15:0] CFG_DELAY_TAG = 16'hFFFF;
  localparam logic [7:0]  DEF_DEV_ADDR  = 8'h78;

  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

endpackage

// File: rtl/ov5640_cfg_rom.sv
// OV5640 init table: {reg_addr[15:0], data[7:0]}; reg_addr 16'hFFFF marks a delay of data ms.
module ov5640_cfg_rom
  import ov5640_pkg::*;
#(
  parameter int unsigned CFG_NUM = 256,
  parameter int unsigned IDX_W   = 9
) (
  input  logic [IDX_W-1:0]      index,
  output logic [CFG_WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    if (32'(index) < CFG_NUM) begin
      case (16'(index))
        16'd0:   word = {16'h3008, 8'h82};
        16'd1:   word = {16'hFFFF, 8'd5};
        16'd2:   word = {16'h3008, 8'h42};
        16'd3:   word = {16'h3103, 8'h03};
        16'd4:   word = {16'h3017, 8'hFF};
        16'd5:   word = {16'h3018, 8'hFF};
        16'd6:   word = {16'h3034, 8'h1A};
        16'd7:   word = {16'h3037, 8'h13};
        16'd8:   word = {16'h3108, 8'h01};
        16'd9:   word = {16'h3630, 8'h36};
        16'd10:  word = {16'h3631, 8'h0E};
        16'd11:  word = {16'h3632, 8'hE2};
        16'd12:  word = {16'h3633, 8'h12};
        16'd13:  word = {16'h3621, 8'hE0};
        16'd14:  word = {16'h3704, 8'hA0};
        16'd15:  word = {16'h3703, 8'h5A};
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Walks the OV5640 init table after power-up and hands each write to the SCCB controller
// through a go-level / trans_finished handshake.
module ov5640_cfg_sequencer
  import ov5640_pkg::*;
#(
  parameter int unsigned SYS_CLOCK_FREQ = 25000000,
  parameter logic [7:0]  DEV_ADDR       = DEF_DEV_ADDR,
  parameter int unsigned CFG_NUM        = 256,
  parameter int unsigned POWERUP_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned IDX_W         = $clog2(CFG_NUM + 1)
) (
  input  logic                  sys_clock,
  input  logic                  rst,
  input  logic                  cfg_restart,
  input  logic                  trans_finished,
  output logic [7:0]            I2C_addr,
  output logic [CFG_WORD_W-1:0] I2C_WDATA,
  output logic                  go,
  output logic [IDX_W-1:0]      cfg_index,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned CYC_PER_MS = SYS_CLOCK_FREQ / 1000;

  cfg_state_e                state;
  logic [CNT_W-1:0]          cnt;
  logic                      rerun;
  logic [CFG_WORD_W-1:0]     rom_word;
  logic [CNT_W-1:0]          cnt_inc_c;
  logic [CNT_W-1:0]          delay_cycles_c;
  logic                      last_c;

  ov5640_cfg_rom #(.CFG_NUM(CFG_NUM), .IDX_W(IDX_W)) u_rom (
    .index (cfg_index),
    .word  (rom_word)
  );

  assign I2C_addr       = DEV_ADDR;
  assign cnt_inc_c      = cnt + CNT_W'(1);
  assign delay_cycles_c = CNT_W'(I2C_WDATA[7:0]) * CNT_W'(CYC_PER_MS);
  assign last_c         = (cfg_index == IDX_W'(CFG_NUM - 1));

  // One counter serves power-up, gap, handshake timeout and delay, cleared on every state entry.
  always_ff @(posedge sys_clock) begin
    if (!rst) begin
      state     <= ST_POWERUP;
      cnt       <= '0;
      rerun     <= 1'b0;
      go        <= 1'b0;
      I2C_WDATA <= '0;
      cfg_index <= '0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else if (cfg_restart) begin
      // Idle out through a gap so an aborted controller transfer can settle.
      state     <= ST_GAP;
      cnt       <= '0;
      rerun     <= 1'b1;
      go        <= 1'b0;
      cfg_index <= '0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      case (state)
        ST_POWERUP: begin
          if (cnt_inc_c >= CNT_W'(POWERUP_CYCLES)) begin
            cnt   <= '0;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_LOAD: begin
          I2C_WDATA <= rom_word;
          cnt       <= '0;
          state     <= (rom_word[23:8] == CFG_DELAY_TAG) ? ST_DELAY : ST_ISSUE;
        end
        ST_ISSUE: begin
          go    <= 1'b1;
          cnt   <= '0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!trans_finished) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt_inc_c >= CNT_W'(TIMEOUT_CYCLES)) begin
            go        <= 1'b0;
            cfg_error <= 1'b1;
            cfg_busy  <= 1'b0;
            state     <= ST_ERROR;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_WAIT_DONE: begin
          if (trans_finished) begin
            go    <= 1'b0;
            cnt   <= '0;
            state <= ST_GAP;
          end else if (cnt_inc_c >= CNT_W'(TIMEOUT_CYCLES)) begin
            go        <= 1'b0;
            cfg_error <= 1'b1;
            cfg_busy  <= 1'b0;
            state     <= ST_ERROR;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_GAP: begin
          if (cnt_inc_c >= CNT_W'(GAP_CYCLES)) begin
            cnt <= '0;
            if (rerun) begin
              rerun <= 1'b0;
              state <= ST_LOAD;
            end else if (last_c) begin
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= ST_DONE;
            end else begin
              cfg_index <= cfg_index + IDX_W'(1);
              state     <= ST_LOAD;
            end
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_DELAY: begin
          if (cnt_inc_c >= delay_cycles_c) begin
            cnt <= '0;
            if (last_c) begin
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= ST_DONE;
            end else begin
              cfg_index <= cfg_index + IDX_W'(1);
              state     <= ST_LOAD;
            end
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_DONE, ST_ERROR: begin
          go <= 1'b0;
        end
        default: begin
          go    <= 1'b0;
          state <= ST_ERROR;
        end
      endcase
    end
  end

endmodule
